data_memory_responder: RTL and testbench

- Responder end of the per-thread LSU data-memory handshake.
- Owns the data memory array and serves NUM_CONSUMERS LSU ports (one read channel and one write channel each) through a round-robin arbiter.
- Serves one operation at a time, with a configurable access latency.
- Sits between the cores' LSU bundles and data storage, and replaces the behavioural testbench memory model.

---
 rtl/data_memory_responder.sv | 135 +++++++++++++
 tb/tb_data_memory_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-memory responder: owns the data array and serves per-consumer LSU read/write channels.
// Latency: ready pulses 1+LATENCY cycles after the IDLE cycle that granted the request.
// Backpressure: one operation in flight; others hold valid until granted (round-robin from rr_ptr).
module data_memory_responder #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 32,
  parameter int LATENCY       = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           mem_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CONSUMERS-1:0]           mem_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CONSUMERS-1:0]           mem_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CONSUMERS-1:0]           mem_write_ready,
  output logic                               busy
);

  localparam int ID_BITS  = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH    = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RELEASE} state_t;

  state_t                state;
  logic [ID_BITS-1:0]    rr_ptr;
  logic [ID_BITS-1:0]    grant_id;
  logic                  op_write;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_BITS-1:0]  wdata_q;
  logic [CNT_BITS-1:0]   cnt;

  logic [DATA_BITS-1:0]  mem [DEPTH];

  logic                  req_found;
  logic [ID_BITS-1:0]    req_id;
  logic                  sel_read;
  logic [ADDR_BITS-1:0]  sel_raddr;
  logic [ADDR_BITS-1:0]  sel_waddr;
  logic [DATA_BITS-1:0]  sel_wdata;
  logic                  granted_valid;
  logic                  mem_commit;
  int                    idx;

  // Round-robin scan: first requester at or after rr_ptr wins; read beats write for that consumer.
  always_comb begin
    req_found = 1'b0;
    req_id    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
      if (!req_found && (mem_read_valid[idx] || mem_write_valid[idx])) begin
        req_found = 1'b1;
        req_id    = ID_BITS'(idx);
      end
    end
    sel_read  = mem_read_valid[req_id];
    sel_raddr = mem_read_address[int'(req_id)*ADDR_BITS +: ADDR_BITS];
    sel_waddr = mem_write_address[int'(req_id)*ADDR_BITS +: ADDR_BITS];
    sel_wdata = mem_write_data[int'(req_id)*DATA_BITS +: DATA_BITS];
  end

  // The granted consumer's valid for the latched op type, watched while releasing.
  always_comb begin
    granted_valid = op_write ? mem_write_valid[grant_id] : mem_read_valid[grant_id];
    mem_commit    = (state == ACCESS) && (cnt == '0) && op_write;
  end

  assign busy = (state != IDLE);

  // Commit a latched write at the end of its access window; reset abandons it.
  always_ff @(posedge clk) begin
    if (!reset && mem_commit) mem[addr_q] <= wdata_q;
  end

  // Request FSM: grant, count out the access latency, pulse ready, wait for valid to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_id        <= '0;
      op_write        <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      cnt             <= '0;
      mem_read_ready  <= '0;
      mem_write_ready <= '0;
      mem_read_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_found) begin
            grant_id <= req_id;
            op_write <= !sel_read;
            addr_q   <= sel_read ? sel_raddr : sel_waddr;
            wdata_q  <= sel_wdata;
            cnt      <= CNT_BITS'(LATENCY - 1);
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (op_write) begin
              mem_write_ready[grant_id] <= 1'b1;
            end else begin
              mem_read_ready[grant_id] <= 1'b1;
              mem_read_data[int'(grant_id)*DATA_BITS +: DATA_BITS] <= mem[addr_q];
            end
            state <= RESPOND;
          end
        end
        RESPOND: begin
          mem_read_ready  <= '0;
          mem_write_ready <= '0;
          state           <= RELEASE;
        end
        RELEASE: begin
          if (!granted_valid) begin
            rr_ptr <= (int'(grant_id) == NUM_CONSUMERS - 1) ? '0 : grant_id + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios plus randomized multi-consumer traffic.
// Consumers follow the hold-until-ready, drop-next-cycle protocol; a reference model predicts grants.
// Grant prediction uses the valid vectors recorded at each cycle and a served-last pointer.
module tb_data_memory_responder;
  localparam int N  = 4;
  localparam int AB = 8;
  localparam int DB = 32;
  localparam int L  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
  logic [N*AB-1:0]   mem_read_address, mem_write_address;
  logic [N*DB-1:0]   mem_read_data, mem_write_data;
  logic              busy;

  data_memory_responder #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int             id;
    bit             wr;
    logic [DB-1:0]  data;
    int             cyc;
  } ev_t;

  ev_t            evq[$];
  bit             req_rd[N], req_wr[N], drop_rd[N], drop_wr[N];
  logic [AB-1:0]  ra[N], wa[N];
  logic [DB-1:0]  wd[N];
  logic [N-1:0]   hist_rv[int], hist_wv[int];
  logic [DB-1:0]  exp_mem[256];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      mem_read_valid[i]            = req_rd[i];
      mem_write_valid[i]           = req_wr[i];
      mem_read_address[i*AB +: AB] = ra[i];
      mem_write_address[i*AB +: AB] = wa[i];
      mem_write_data[i*DB +: DB]   = wd[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      req_rd[i] = 0; req_wr[i] = 0; drop_rd[i] = 0; drop_wr[i] = 0;
      ra[i] = '0; wa[i] = '0; wd[i] = '0;
    end
  endtask

  // One clock: apply protocol drops, drive, record valids, collect ready pulses.
  task automatic tick();
    ev_t e;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (drop_rd[i]) begin req_rd[i] = 0; drop_rd[i] = 0; end
      if (drop_wr[i]) begin req_wr[i] = 0; drop_wr[i] = 0; end
    end
    drive();
    hist_rv[cyc] = mem_read_valid;
    hist_wv[cyc] = mem_write_valid;
    for (int i = 0; i < N; i++) begin
      if (mem_read_ready[i]) begin
        e.id = i; e.wr = 1'b0; e.data = mem_read_data[i*DB +: DB]; e.cyc = cyc;
        evq.push_back(e); drop_rd[i] = 1;
      end
      if (mem_write_ready[i]) begin
        e.id = i; e.wr = 1'b1; e.data = '0; e.cyc = cyc;
        evq.push_back(e); drop_wr[i] = 1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    drive();
    tick();
    tick();
    reset = 1'b0;
    evq.delete();
  endtask

  task automatic wait_events(input int n, input int max_cyc, output bit timed_out);
    int k = 0;
    while (evq.size() < n && k < max_cyc) begin
      tick();
      k++;
    end
    timed_out = (evq.size() < n);
  endtask

  task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
    bit to;
    wa[0] = a; wd[0] = d; req_wr[0] = 1;
    wait_events(1, 50, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL preload_timeout: addr=%0h got no write_ready in 50 cycles, required one", a);
    end
    evq.delete();
    exp_mem[a] = d;
    tick();
  endtask

  task automatic single_read(input int id, input logic [AB-1:0] a,
                             output logic [DB-1:0] d, output bit to);
    ra[id] = a; req_rd[id] = 1;
    wait_events(1, 50, to);
    d = to ? 'x : evq[0].data;
    evq.delete();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (mem_read_ready !== '0) begin miscompares++; $display("FAIL reset_read_ready: got %b, required 0", mem_read_ready); end
    vectors++; if (mem_write_ready !== '0) begin miscompares++; $display("FAIL reset_write_ready: got %b, required 0", mem_write_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    vectors++; if (mem_read_data !== '0) begin miscompares++; $display("FAIL reset_read_data: got %h, required 0", mem_read_data); end
  endtask

  task automatic test_write_read();
    bit to; int t0; ev_t e; logic [DB-1:0] d;
    do_reset();
    wa[0] = 8'h10; wd[0] = 32'hDEADBEEF; req_wr[0] = 1;
    tick(); t0 = cyc;
    wait_events(1, 20, to);
    vectors++;
    if (to) begin
      miscompares++; $display("FAIL wr_timeout: got no write_ready in 20 cycles, required one");
    end else begin
      e = evq.pop_front();
      vectors++; if (!(e.id == 0 && e.wr)) begin miscompares++; $display("FAIL wr_who: got id=%0d wr=%0b, required id=0 wr=1", e.id, e.wr); end
      vectors++; if (e.cyc - t0 != L + 1) begin miscompares++; $display("FAIL wr_latency: got %0d, required %0d", e.cyc - t0, L + 1); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %b, required 1", busy); end
      tick();
      vectors++; if (mem_write_ready !== '0) begin miscompares++; $display("FAIL wr_pulse_width: got %b, required 0", mem_write_ready); end
    end
    exp_mem[8'h10] = 32'hDEADBEEF;
    single_read(0, 8'h10, d, to);
    vectors++; if (to || d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_after_wr: got %h (timeout=%0b), required deadbeef", d, to); end
  endtask

  task automatic test_round_robin();
    bit to; bit again = 0; int k = 0;
    int exp_id[4] = '{1, 2, 3, 1};
    logic [DB-1:0] exp_d[4] = '{32'd11, 32'd22, 32'd33, 32'd11};
    do_reset();
    preload(8'd1, 32'd11); preload(8'd2, 32'd22); preload(8'd3, 32'd33);
    do_reset();
    for (int i = 1; i < N; i++) begin ra[i] = AB'(i); req_rd[i] = 1; end
    while (evq.size() < 4 && k < 200) begin
      tick(); k++;
      if (!again && evq.size() >= 1 && !req_rd[1] && !drop_rd[1]) begin req_rd[1] = 1; again = 1; end
    end
    vectors++;
    if (evq.size() < 4) begin
      miscompares++; $display("FAIL rr_timeout: got %0d completions, required 4", evq.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (evq[j].id != exp_id[j] || evq[j].wr || evq[j].data !== exp_d[j]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: got id=%0d wr=%0b data=%0d, required id=%0d read data=%0d",
                   j, evq[j].id, evq[j].wr, evq[j].data, exp_id[j], exp_d[j]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int k = 0;
    do_reset();
    ra[0] = 8'd1; ra[3] = 8'd2;
    req_rd[0] = 1; req_rd[3] = 1;
    while (evq.size() < 6 && k < 300) begin
      tick(); k++;
      if (!req_rd[0] && !drop_rd[0]) req_rd[0] = 1;
      if (!req_rd[3] && !drop_rd[3]) req_rd[3] = 1;
    end
    vectors++;
    if (evq.size() < 6) begin
      miscompares++; $display("FAIL fair_timeout: got %0d completions, required 6", evq.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        vectors++;
        if (evq[j].id != ((j % 2 == 0) ? 0 : 3)) begin
          miscompares++; $display("FAIL fair_order[%0d]: got id=%0d, required %0d", j, evq[j].id, (j % 2 == 0) ? 0 : 3);
        end
      end
    end
  endtask

  task automatic test_rw_same();
    bit to; int k = 0; logic [DB-1:0] d;
    do_reset();
    preload(8'd5, 32'h1234_5678);
    ra[2] = 8'd5; wa[2] = 8'd5; wd[2] = 32'd7;
    req_rd[2] = 1; req_wr[2] = 1;
    wait_events(2, 80, to);
    vectors++;
    if (to) begin
      miscompares++; $display("FAIL rw_timeout: got %0d completions, required 2", evq.size());
    end else begin
      vectors++; if (evq[0].id != 2 || evq[0].wr || evq[0].data !== 32'h1234_5678) begin
        miscompares++; $display("FAIL rw_first: got id=%0d wr=%0b data=%h, required id=2 read data=12345678", evq[0].id, evq[0].wr, evq[0].data); end
      vectors++; if (evq[1].id != 2 || !evq[1].wr) begin
        miscompares++; $display("FAIL rw_second: got id=%0d wr=%0b, required id=2 wr=1", evq[1].id, evq[1].wr); end
    end
    evq.delete();
    while ((req_wr[2] || drop_wr[2] || drop_rd[2]) && k < 20) begin tick(); k++; end
    single_read(2, 8'd5, d, to);
    vectors++; if (to || d !== 32'd7) begin miscompares++; $display("FAIL rw_readback: got %h (timeout=%0b), required 7", d, to); end
  endtask

  task automatic test_reset_midop();
    bit to; logic [DB-1:0] d;
    do_reset();
    preload(8'd9, 32'hAAAA_0000);
    single_read(0, 8'd9, d, to);
    vectors++; if (to || d !== 32'hAAAA_0000) begin miscompares++; $display("FAIL midop_preread: got %h, required aaaa0000", d); end
    wa[0] = 8'd9; wd[0] = 32'h55; req_wr[0] = 1;
    tick();
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midop_busy_before: got %b, required 1", busy); end
    reset = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midop_busy: got %b, required 0", busy); end
    vectors++; if ((mem_read_ready | mem_write_ready) !== '0) begin miscompares++; $display("FAIL midop_ready: got %b/%b, required 0", mem_read_ready, mem_write_ready); end
    vectors++; if (mem_read_data !== '0) begin miscompares++; $display("FAIL midop_read_data: got %h, required 0", mem_read_data); end
    vectors++; if (evq.size() != 0) begin miscompares++; $display("FAIL midop_no_pulse: got %0d pulses, required 0", evq.size()); end
    clear_reqs();
    tick();
    reset = 1'b0;
    evq.delete();
    tick();
    single_read(1, 8'd9, d, to);
    vectors++; if (to || d !== 32'hAAAA_0000) begin miscompares++; $display("FAIL midop_array: got %h (timeout=%0b), required aaaa0000", d, to); end
  endtask

  task automatic test_data_hold();
    bit to; logic [DB-1:0] d; int k;
    do_reset();
    preload(8'd20, 32'd42);
    single_read(1, 8'd20, d, to);
    vectors++; if (to || d !== 32'd42) begin miscompares++; $display("FAIL hold_read: got %0d, required 42", d); end
    for (int w = 0; w < 3; w++) begin
      wa[0] = AB'(20 + w); wd[0] = DB'(99 + w); req_wr[0] = 1;
      k = 0;
      while ((req_wr[0] || drop_wr[0]) && k < 40) begin
        tick(); k++;
        vectors++;
        if (mem_read_data[1*DB +: DB] !== 32'd42 || mem_read_ready[1] !== 1'b0) begin
          miscompares++; $display("FAIL hold_data: got data=%0d ready=%b, required 42/0", mem_read_data[1*DB +: DB], mem_read_ready[1]);
        end
      end
      vectors++; if (k >= 40) begin miscompares++; $display("FAIL hold_timeout: write %0d got no completion, required one", w); end
      evq.delete();
    end
  endtask

  task automatic test_random();
    int model_ptr = 0; int gi; int exp_id; bit exp_rd; int pidx; int idle_cnt;
    logic [2*N-1:0] prev_rdy = '0, cur_rdy;
    ev_t e;
    do_reset();
    for (int a = 0; a < 16; a++) preload(AB'(a), $urandom);
    do_reset();
    for (int t = 0; t < 1700; t++) begin
      tick();
      cur_rdy = {mem_read_ready, mem_write_ready};
      vectors++; if ($countones(cur_rdy) > 1) begin miscompares++; $display("FAIL rand_onehot: got %b, required at most one bit", cur_rdy); end
      vectors++; if ((cur_rdy & prev_rdy) != '0) begin miscompares++; $display("FAIL rand_pulse: got %b after %b, required single-cycle pulses", cur_rdy, prev_rdy); end
      prev_rdy = cur_rdy;
      while (evq.size() > 0) begin
        e = evq.pop_front();
        gi = e.cyc - L - 1;
        exp_id = -1; exp_rd = 0;
        if (hist_rv.exists(gi)) begin
          for (int k = 0; k < N; k++) begin
            pidx = (model_ptr + k) % N;
            if (exp_id < 0 && (hist_rv[gi][pidx] || hist_wv[gi][pidx])) exp_id = pidx;
          end
          if (exp_id >= 0) exp_rd = hist_rv[gi][exp_id];
        end
        vectors++;
        if (e.id != exp_id || e.wr != !exp_rd) begin
          miscompares++; $display("FAIL rand_grant: got id=%0d wr=%0b, required id=%0d wr=%0b", e.id, e.wr, exp_id, !exp_rd);
        end
        if (!e.wr) begin
          vectors++;
          if (e.data !== exp_mem[ra[e.id]]) begin
            miscompares++; $display("FAIL rand_data: id=%0d addr=%0d got %h, required %h", e.id, ra[e.id], e.data, exp_mem[ra[e.id]]);
          end
        end else begin
          exp_mem[wa[e.id]] = wd[e.id];
        end
        model_ptr = (e.id + 1) % N;
      end
      if (t < 1500) begin
        for (int i = 0; i < N; i++) begin
          if (!req_rd[i] && !req_wr[i] && !drop_rd[i] && !drop_wr[i] && $urandom_range(0, 3) == 0) begin
            ra[i] = AB'($urandom_range(0, 15));
            wa[i] = AB'($urandom_range(0, 15));
            wd[i] = $urandom;
            case ($urandom_range(0, 2))
              0: req_rd[i] = 1;
              1: req_wr[i] = 1;
              default: begin req_rd[i] = 1; req_wr[i] = 1; end
            endcase
          end
        end
      end
    end
    idle_cnt = 0;
    for (int i = 0; i < N; i++) if (req_rd[i] || req_wr[i]) idle_cnt++;
    vectors++; if (idle_cnt != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL rand_drain: got %0d consumers pending busy=%b, required 0/0", idle_cnt, busy); end
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    drive();
    test_reset();
    test_write_read();
    test_round_robin();
    test_fairness();
    test_rw_same();
    test_reset_midop();
    test_data_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
